// File: rtl/serial_paralelo_rx_if.sv
// Bus bundle for serial_paralelo_rx: serial input, byte output and link/debug status.
// byte_cnt exists only when SP_BYTE_CNT_EN is defined.
interface serial_paralelo_rx_if;
    // valid_out has no ready: data_out is a fresh byte for the 8 cycles valid_out is high,
    // and the consumer must take it within that window.
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [1:0] state;
    logic [3:0] com_cnt;
`ifdef SP_BYTE_CNT_EN
    logic [15:0] byte_cnt;
`endif

    // master: upstream serial source / observer; slave: the receiver itself
    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  state,
        input  com_cnt
`ifdef SP_BYTE_CNT_EN
        ,
        input  byte_cnt
`endif
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output state,
        output com_cnt
`ifdef SP_BYTE_CNT_EN
        ,
        output byte_cnt
`endif
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for COM alignment, locks after COM_LOCK COMs, emits data bytes.
// Optional feature macro: SP_BYTE_CNT_EN adds a 16-bit delivered-byte counter.
module serial_paralelo_rx #(
    parameter logic [7:0] COM_BYTE = 8'hBC,
    parameter int         COM_LOCK = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(COM_LOCK);

    state_t     state_q, state_n;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic [3:0] com_cnt_q, com_cnt_n;
    logic [7:0] data_q, data_n;
    logic       valid_q, valid_n;
    logic [7:0] window;
    logic       is_com;
    logic       boundary;
    logic [3:0] com_cnt_inc;
`ifdef SP_BYTE_CNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_n;
`endif

    // The byte completing on this edge includes the bit being sampled now.
    assign window      = {sr_q[6:0], bus.data_in};
    assign is_com      = (window == COM_BYTE);
    assign boundary    = (bit_cnt_q == 3'd7);
    assign com_cnt_inc = com_cnt_q + 4'd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= SEARCH;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            com_cnt_q  <= 4'd0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
`ifdef SP_BYTE_CNT_EN
            byte_cnt_q <= 16'h0000;
`endif
        end else begin
            state_q    <= state_n;
            sr_q       <= window;
            bit_cnt_q  <= bit_cnt_n;
            com_cnt_q  <= com_cnt_n;
            data_q     <= data_n;
            valid_q    <= valid_n;
`ifdef SP_BYTE_CNT_EN
            byte_cnt_q <= byte_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n    = state_q;
        bit_cnt_n  = bit_cnt_q + 3'd1;
        com_cnt_n  = com_cnt_q;
        data_n     = data_q;
        valid_n    = valid_q;
`ifdef SP_BYTE_CNT_EN
        byte_cnt_n = byte_cnt_q;
`endif
        case (state_q)
            SEARCH: begin
                valid_n   = 1'b0;
                bit_cnt_n = 3'd0;
                // A match at any bit offset defines where the next byte starts.
                if (is_com) begin
                    com_cnt_n = 4'd1;
                    state_n   = (LOCK_CNT == 4'd1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                valid_n = 1'b0;
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_n = com_cnt_inc;
                        if (com_cnt_inc == LOCK_CNT) begin
                            state_n = ACTIVE;
                        end
                    end else begin
                        com_cnt_n = 4'd0;
                        state_n   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        valid_n = 1'b0;
                    end else begin
                        data_n  = window;
                        valid_n = 1'b1;
`ifdef SP_BYTE_CNT_EN
                        byte_cnt_n = byte_cnt_q + 16'd1;
`endif
                    end
                end
            end
            default: begin
                state_n   = SEARCH;
                com_cnt_n = 4'd0;
                valid_n   = 1'b0;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = (state_q == ACTIVE);
    assign bus.state     = state_q;
    assign bus.com_cnt   = com_cnt_q;
`ifdef SP_BYTE_CNT_EN
    assign bus.byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: reset, aligned/misaligned lock, idle interleave, abort, mid-run reset.
// Expected values are hand-computed from the byte stream sent MSB first.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    serial_paralelo_rx_if bus();

    serial_paralelo_rx #(.COM_BYTE(8'hBC), .COM_LOCK(4)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, return #1 after the rising edge that sampled the bit.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            reset       = 1'b1;
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b0;
    endtask

    // Data byte just completed: compare against the scoreboard head.
    task automatic check_data(input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check_eq({tag, "_valid"}, bus.valid_out, 1'b1);
            check_eq({tag, "_data"}, bus.data_out, exp);
        end
    endtask

    initial begin
        bus.data_in = 1'b0;

        // Reset: outputs clear on the first edge with reset high.
        @(negedge clk_32f);
        bus.data_in = 1'($urandom_range(0, 1));
        @(posedge clk_32f);
        #1;
        check_eq("rst_data", bus.data_out, 8'h00);
        check_eq("rst_valid", bus.valid_out, 1'b0);
        check_eq("rst_active", bus.active, 1'b0);
        check_eq("rst_state", bus.state, 2'd0);
        check_eq("rst_com_cnt", bus.com_cnt, 4'd0);
`ifdef SP_BYTE_CNT_EN
        check_eq("rst_byte_cnt", bus.byte_cnt, 16'd0);
`endif
        reset_cycles(2);

        // Aligned lock: active rises on the edge sampling bit 31.
        send_byte(COM);
        check_eq("al_state_align", bus.state, 2'd1);
        send_byte(COM);
        send_byte(COM);
        check_eq("al_com_cnt3", bus.com_cnt, 4'd3);
        send_bits(COM, 7);
        check_eq("al_active_bit30", bus.active, 1'b0);
        send_bit(COM[0]);
        check_eq("al_active_bit31", bus.active, 1'b1);
        check_eq("al_valid_com", bus.valid_out, 1'b0);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        send_byte(8'h5A);
        check_data("al_5a");
        send_bits(8'hC3, 7);
        check_eq("al_5a_hold_valid", bus.valid_out, 1'b1);
        check_eq("al_5a_hold_data", bus.data_out, 8'h5A);
        send_bit(1'b1);
        check_data("al_c3");

        // Idle interleave while active.
        exp_q.push_back(8'h22);
        send_byte(8'h22);
        check_data("il_22");
        send_byte(COM);
        check_eq("il_com_valid", bus.valid_out, 1'b0);
        check_eq("il_com_hold", bus.data_out, 8'h22);
        exp_q.push_back(8'h33);
        send_byte(8'h33);
        check_data("il_33");
`ifdef SP_BYTE_CNT_EN
        check_eq("il_byte_cnt", bus.byte_cnt, 16'd4);
`endif

        // Reset mid-byte while active.
        send_bits(8'hA5, 3);
        reset_cycles(1);
        check_eq("mr_active", bus.active, 1'b0);
        check_eq("mr_valid", bus.valid_out, 1'b0);
        check_eq("mr_data", bus.data_out, 8'h00);
        check_eq("mr_state", bus.state, 2'd0);
`ifdef SP_BYTE_CNT_EN
        check_eq("mr_byte_cnt", bus.byte_cnt, 16'd0);
`endif

        // Misaligned start after reset: 3 junk bits, 5 COMs, then 0x11.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check_eq("ma_state_search", bus.state, 2'd0);
        send_byte(COM);
        send_byte(COM);
        send_byte(COM);
        check_eq("ma_active_com3", bus.active, 1'b0);
        send_byte(COM);
        check_eq("ma_active_com4", bus.active, 1'b1);
        send_byte(COM);
        check_eq("ma_valid_com5", bus.valid_out, 1'b0);
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        check_data("ma_11");
`ifdef SP_BYTE_CNT_EN
        check_eq("ma_byte_cnt", bus.byte_cnt, 16'd1);
`endif

        // Lock abort: 2 COMs then 0x00 drops back to SEARCH, then relock.
        reset_cycles(2);
        send_byte(COM);
        send_byte(COM);
        check_eq("ab_com_cnt2", bus.com_cnt, 4'd2);
        send_byte(8'h00);
        check_eq("ab_state", bus.state, 2'd0);
        check_eq("ab_com_cnt0", bus.com_cnt, 4'd0);
        check_eq("ab_active", bus.active, 1'b0);
        send_byte(COM);
        send_byte(COM);
        send_byte(COM);
        check_eq("ab_active_com3", bus.active, 1'b0);
        send_byte(COM);
        check_eq("ab_active_com4", bus.active, 1'b1);
        check_eq("ab_valid", bus.valid_out, 1'b0);
        check_eq("ab_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side serial-to-parallel converter sitting directly downstream of `phy_tx`. It takes the single-bit serial stream `phy_tx` produces, finds byte alignment by hunting for the COM (idle) character 0xBC, and declares the link active after a run of consecutive COMs. Once active, it delivers each non-COM byte on an 8-bit bus with a valid flag for the receive-side lane un-striper.

## Interface
Parameters:
- `COM_BYTE`, 8'hBC, idle/comma character transmitted when no data is valid
- `COM_LOCK`, 4, consecutive aligned COM bytes required to enter ACTIVE (legal range 1..15)

Ports:
- `clk_32f`  input  1  bit clock; one serial bit per rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in`  input  1  serial data from `phy_tx`, MSB first
- `data_out`  output  8  last received data byte
- `valid_out`  output  1  `data_out` holds a data byte (not COM)
- `active`  output  1  link aligned and locked

## Operation
- Shift register `sr[7:0]` shifts left each edge: `sr <= {sr[6:0], data_in}`. The window is `{sr[6:0], data_in}`.
- 3-bit bit counter `bit_cnt` and 4-bit `com_cnt`.
- States:
  - SEARCH: compared every edge. If window == `COM_BYTE`, set `bit_cnt <= 0` (the next bit is the MSB of the next byte) and `com_cnt <= 1`. Go to ALIGN, or directly to ACTIVE if `COM_LOCK == 1`. Otherwise stay.
  - ALIGN: `bit_cnt` increments each edge. At a byte boundary (`bit_cnt == 7`), evaluate the window:
    - COM: increment `com_cnt`. On reaching `COM_LOCK`, go to ACTIVE.
    - Non-COM: clear `com_cnt` and return to SEARCH. Realignment starts on the following edges.
  - ACTIVE: `active = 1`. At each byte boundary:
    - non-COM window: `data_out <= window`, `valid_out <= 1`.
    - COM window: `valid_out <= 0`, `data_out` holds.
    - ACTIVE is left only by reset.
- `valid_out` is 0 in SEARCH and ALIGN. `data_out` is never written outside ACTIVE.
- A COM run longer than `COM_LOCK` before data is legal; extra COMs keep `valid_out` low.

## Timing
- Reset (sampled on a `clk_32f` edge) sets: `sr = 0`, `bit_cnt = 0`, `com_cnt = 0`, state SEARCH, `data_out = 8'h00`, `valid_out = 0`, `active = 0`.
- Reset mid-byte or while ACTIVE aborts immediately. Alignment must be reacquired.
- Output latency:
  - `data_out`/`valid_out` update on the same edge that samples the byte's LSB, so they are visible in the cycle after.
  - They are then stable for exactly 8 cycles, until the next byte boundary.
- `active` rises on the edge that samples the LSB of the `COM_LOCK`-th COM, and is stable thereafter.
- Minimum time from reset release to `active` is 8·`COM_LOCK` cycles when the stream is already aligned.
- In SEARCH, a match can occur at any bit offset. A false match inside data is rejected at the next boundary check in ALIGN.

## Configuration
- `SP_BYTE_CNT_EN`:
  - Defined: adds output `byte_cnt` (16-bit), reset to 0. It increments on every boundary where `valid_out` is set to 1, wraps 16'hFFFF→0, and is cleared only by reset.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset check: `reset` high for 3 cycles with `data_in` random → all outputs 0, state SEARCH, on the first edge after assertion.
- Aligned lock: 4×0xBC, then 0x5A, 0xC3, MSB first, with default parameters:
  - `active` rises at the edge sampling bit 31.
  - `data_out` = 0x5A with `valid_out` = 1 for 8 cycles, then 0xC3.
- Misaligned start: 3 junk bits, then 5×0xBC, then 0x11 → lock after the 4th aligned COM, `data_out` = 0x11, `valid_out` = 1.
- Idle interleave while ACTIVE: 0x22, 0xBC, 0x33:
  - `valid_out` goes 1 (0x22), then 0 for 8 cycles while `data_out` holds 0x22, then 1 (0x33).
- Lock abort: 2×0xBC, then 0x00 → state returns to SEARCH, `com_cnt` = 0, `active` stays 0. Then 4×0xBC → lock.
- Reset mid-operation: assert `reset` for 1 cycle while ACTIVE, mid-byte → `active`/`valid_out` drop to 0 on that edge, and relock needs a fresh 4×0xBC. With `SP_BYTE_CNT_EN`, `byte_cnt` returns to 0.
